tone_detector: RTL and testbench

Receive-side counterpart of the buzzer tone generators. Measures the period of an incoming square wave on the speaker/comparator line and locks onto one of two nominal tones. Tone A is 440 Hz, period 56820 clk; tone B is 880 Hz, period 28410 clk. The block reports which tone is present and, optionally, flags the two-tone siren pattern. It sits at the board input next to the generators and is used for loopback self-test and alarm detection.

---
 rtl/tone_detector.sv | 206 ++++++++++++++++++++
 tb/tb_tone_detector.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_detector.sv
// tone_detector: measures the period of a square wave and locks onto tone A or tone B.
// Define TONE_DET_SIREN_EN to build the A/B siren tracker; otherwise siren_active is tied to 0.
module tone_detector #(
    parameter int CLK_HZ  = 25000000,
    parameter int PER_A   = 56820,
    parameter int PER_B   = 28410,
    parameter int TOL     = 256,
    parameter int LOCK_N  = 4,
    parameter int TIMEOUT = 131072,
    parameter int SEG_MIN = 20000000,
    parameter int SEG_MAX = 30000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tone_in,
    output logic        tone_valid,
    output logic        tone_id,
    output logic [17:0] period,
    output logic        tone_err,
    output logic        siren_active
);

    // Out-of-range settings fall back to the slowest lock instead of wrapping the 4-bit counter.
    localparam bit         CFG_OK  = (CLK_HZ > 0) && (LOCK_N >= 2) && (LOCK_N <= 15) && (SEG_MIN <= SEG_MAX);
    localparam logic [3:0] LOCK_V  = CFG_OK ? 4'(LOCK_N) : 4'd15;
    localparam int         A_LO    = (PER_A > TOL) ? PER_A - TOL : 0;
    localparam int         A_HI    = PER_A + TOL;
    localparam int         B_LO    = (PER_B > TOL) ? PER_B - TOL : 0;
    localparam int         B_HI    = PER_B + TOL;
    localparam logic [17:0] CNT_LAST = 18'(TIMEOUT - 1);

    typedef enum logic [1:0] {SILENT, ACQ, LOCKED} state_t;
    typedef enum logic [1:0] {CLS_A, CLS_B, CLS_NONE} cls_t;

    logic        r_sync1, r_sync2, r_delay;
    logic        w_edge;
    logic [17:0] r_per_cnt;
    logic [18:0] w_meas;
    logic        w_timeout;
    cls_t        w_cls;
    logic        w_cls_b;

    state_t      r_state, w_state_nxt;
    logic        r_cand, w_cand_nxt;
    logic [3:0]  r_match_cnt, w_match_nxt, w_match_inc;
    logic        w_err_nxt;
    logic        w_lock_entry;

    logic        r_tone_valid, r_tone_id, r_tone_err;
    logic [17:0] r_period;

    assign w_edge      = r_sync2 & ~r_delay;
    assign w_meas      = {1'b0, r_per_cnt} + 19'd1;
    assign w_timeout   = (r_per_cnt == CNT_LAST) && !w_edge;
    assign w_cls_b     = (w_cls == CLS_B);
    assign w_match_inc = r_match_cnt + 4'd1;
    assign w_lock_entry = (w_state_nxt == LOCKED) && (r_state != LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_delay   <= 1'b0;
            r_per_cnt <= '0;
        end else begin
            r_sync1 <= tone_in;
            r_sync2 <= r_sync1;
            r_delay <= r_sync2;
            if (w_edge) begin
                r_per_cnt <= '0;
            end else if (r_per_cnt != CNT_LAST) begin
                r_per_cnt <= r_per_cnt + 18'd1;
            end
        end
    end

    always_comb begin
        w_cls = CLS_NONE;
        if (w_meas >= 19'(A_LO) && w_meas <= 19'(A_HI)) begin
            w_cls = CLS_A;
        end else if (w_meas >= 19'(B_LO) && w_meas <= 19'(B_HI)) begin
            w_cls = CLS_B;
        end
    end

    // An edge always takes priority over the silence timeout in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_match_nxt = r_match_cnt;
        w_err_nxt   = 1'b0;
        if (w_edge) begin
            case (r_state)
                SILENT: begin
                    w_state_nxt = ACQ;
                    w_match_nxt = 4'd0;
                end
                ACQ: begin
                    if (w_cls == CLS_NONE) begin
                        w_match_nxt = 4'd0;
                        w_err_nxt   = 1'b1;
                    end else if (w_cls_b == r_cand && r_match_cnt != 4'd0) begin
                        w_match_nxt = w_match_inc;
                        if (w_match_inc == LOCK_V) w_state_nxt = LOCKED;
                    end else begin
                        w_cand_nxt  = w_cls_b;
                        w_match_nxt = 4'd1;
                    end
                end
                LOCKED: begin
                    if (w_cls == CLS_NONE) begin
                        w_state_nxt = ACQ;
                        w_match_nxt = 4'd0;
                        w_err_nxt   = 1'b1;
                    end else if (w_cls_b != r_cand) begin
                        w_state_nxt = ACQ;
                        w_cand_nxt  = w_cls_b;
                        w_match_nxt = 4'd1;
                    end
                end
                default: w_state_nxt = SILENT;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = SILENT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SILENT;
            r_cand       <= 1'b0;
            r_match_cnt  <= 4'd0;
            r_tone_valid <= 1'b0;
            r_tone_id    <= 1'b0;
            r_tone_err   <= 1'b0;
            r_period     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cand       <= w_cand_nxt;
            r_match_cnt  <= w_match_nxt;
            r_tone_valid <= (w_state_nxt == LOCKED);
            r_tone_err   <= w_err_nxt;
            if (w_lock_entry) r_tone_id <= r_cand;
            if (w_edge && r_state != SILENT) r_period <= w_meas[17:0];
        end
    end

    assign tone_valid = r_tone_valid;
    assign tone_id    = r_tone_id;
    assign tone_err   = r_tone_err;
    assign period     = r_period;

`ifdef TONE_DET_SIREN_EN
    localparam logic [24:0] SEG_LO  = 25'(SEG_MIN);
    localparam logic [24:0] SEG_HI  = 25'(SEG_MAX);
    localparam logic [24:0] SEG_SAT = 25'(SEG_MAX + 1);

    logic [24:0] r_seg_cnt;
    logic [1:0]  r_sw_cnt;
    logic        r_last_id, r_have_last, r_siren;
    logic        w_in_win;

    assign w_in_win = (r_seg_cnt >= SEG_LO) && (r_seg_cnt <= SEG_HI);

    // A segment is the time between locks on different tones; two good segments in a row mean siren.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_cnt   <= '0;
            r_sw_cnt    <= 2'd0;
            r_last_id   <= 1'b0;
            r_have_last <= 1'b0;
            r_siren     <= 1'b0;
        end else if (w_timeout) begin
            r_seg_cnt   <= '0;
            r_sw_cnt    <= 2'd0;
            r_last_id   <= 1'b0;
            r_have_last <= 1'b0;
            r_siren     <= 1'b0;
        end else begin
            if (r_seg_cnt != SEG_SAT) r_seg_cnt <= r_seg_cnt + 25'd1;
            if (r_seg_cnt == SEG_SAT) r_sw_cnt <= 2'd0;
            if (w_lock_entry) begin
                if (!r_have_last) begin
                    r_have_last <= 1'b1;
                    r_seg_cnt   <= '0;
                    r_last_id   <= r_cand;
                end else if (r_cand != r_last_id) begin
                    if (w_in_win) begin
                        r_sw_cnt <= (r_sw_cnt == 2'd2) ? 2'd2 : r_sw_cnt + 2'd1;
                    end else begin
                        r_sw_cnt <= 2'd0;
                    end
                    r_seg_cnt <= '0;
                    r_last_id <= r_cand;
                end
            end
            r_siren <= (r_sw_cnt == 2'd2);
        end
    end

    assign siren_active = r_siren;
`else
    assign siren_active = 1'b0;
`endif

endmodule

// File: tb/tb_tone_detector.sv
// tb_tone_detector: randomized edge-interval stimulus checked against a run-length reference model.
// Siren expectations follow TONE_DET_SIREN_EN; without it siren_active must stay 0.
`timescale 1ns/1ps
module tb_tone_detector;

    localparam int PA    = 200;
    localparam int PB    = 100;
    localparam int TOLV  = 8;
    localparam int LOCKN = 4;
    localparam int TMO   = 512;
    localparam int SMIN  = 1500;
    localparam int SMAX  = 3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tone_in = 1'b0;
    logic        tone_valid, tone_id, tone_err, siren_active;
    logic [17:0] period;

    tone_detector #(
        .CLK_HZ(25000000), .PER_A(PA), .PER_B(PB), .TOL(TOLV), .LOCK_N(LOCKN),
        .TIMEOUT(TMO), .SEG_MIN(SMIN), .SEG_MAX(SMAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tone_in(tone_in), .tone_valid(tone_valid),
        .tone_id(tone_id), .period(period), .tone_err(tone_err), .siren_active(siren_active)
    );

    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;
    int cyc = 0;
    int errSeen = 0;

    always @(negedge clk) if (tone_err === 1'b1) errSeen++;

    // Reference model: tone state, error count and siren history.
    bit mSilent, mValid, mId, mHaveRise;
    int mRun, mClass, mPeriod, mErrExp, mLastRise;
    bit sHave, sUnsure;
    int sLastId, sLastT, sSw;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    function automatic int classify(input int m);
        if (m - PA <= TOLV && PA - m <= TOLV) return 0;
        if (m - PB <= TOLV && PB - m <= TOLV) return 1;
        return 2;
    endfunction

    function automatic bit nearBound(input int v, input int b);
        return (v - b < 8) && (b - v < 8);
    endfunction

    task automatic sirenClear();
        sHave = 0; sSw = 0; sUnsure = 0;
    endtask

    task automatic modelReset();
        mSilent = 1; mValid = 0; mId = 0; mPeriod = 0; mRun = 0; mClass = -1; mHaveRise = 0;
        sirenClear();
    endtask

    task automatic modelTimeout();
        mSilent = 1; mValid = 0; mRun = 0;
        sirenClear();
    endtask

    task automatic modelLock(input int t, input int id);
        int seg;
        if (!sHave) begin
            sHave = 1; sLastId = id; sLastT = t;
        end else if (id != sLastId) begin
            seg = t - sLastT;
            if (nearBound(seg, SMIN) || nearBound(seg, SMAX)) sUnsure = 1;
            if (seg >= SMIN && seg <= SMAX) sSw = (sSw >= 2) ? 2 : sSw + 1;
            else sSw = 0;
            sLastT = t; sLastId = id;
        end
    endtask

    task automatic modelEdge(input int t);
        int meas, c;
        bit was;
        if (mHaveRise && (t - mLastRise > TMO)) modelTimeout();
        meas = t - mLastRise;
        mHaveRise = 1;
        mLastRise = t;
        if (mSilent) begin
            mSilent = 0; mRun = 0; mClass = -1;
            return;
        end
        mPeriod = meas;
        c = classify(meas);
        was = mValid;
        if (c == 2) begin
            mRun = 0;
            mErrExp++;
        end else if (c == mClass && mRun > 0) begin
            mRun++;
        end else begin
            mClass = c;
            mRun = 1;
        end
        mValid = (mRun >= LOCKN);
        if (mValid && !was) begin
            mId = mClass[0];
            modelLock(t, mClass);
        end
    endtask

    function automatic bit expSiren(input int now);
`ifdef TONE_DET_SIREN_EN
        return (sSw == 2) && (now - sLastT <= SMAX);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit sirenCheckable(input int now);
        return !sUnsure && !(sSw == 2 && now - sLastT > SMAX - 24 && now - sLastT < SMAX + 24);
    endfunction

    task automatic checkState(input string tag);
        checkOutput({tag, ".valid"}, tone_valid, mValid);
        checkOutput({tag, ".id"}, tone_id, mId);
        checkOutput({tag, ".period"}, period, mPeriod);
        checkOutput({tag, ".errcnt"}, errSeen, mErrExp);
        if (sirenCheckable(cyc)) checkOutput({tag, ".siren"}, siren_active, expSiren(cyc));
    endtask

    // One rising edge on tone_in, gap cycles after the previous one, then check 5 cycles later.
    task automatic applyStimulus(input int gap);
        tick(gap - 5);
        tone_in = 1'b1;
        modelEdge(cyc);
        tick(5);
        checkState("edge");
        tone_in = 1'b0;
    endtask

    task automatic holdLow(input int n);
        tick(n);
        if (mHaveRise && (cyc - mLastRise > TMO + 4)) modelTimeout();
        checkState("hold");
    endtask

    task automatic randomMix(input int edges);
        int left;
        left = edges;
        while (left > 0) begin
            int kind;
            int runLen;
            int gap;
            kind = int'($urandom_range(0, 9));
            runLen = int'($urandom_range(1, 7));
            repeat (runLen) begin
                if (kind < 5) gap = PA - TOLV + int'($urandom_range(0, 2 * TOLV));
                else if (kind < 9) gap = PB - TOLV + int'($urandom_range(0, 2 * TOLV));
                else gap = 110 + int'($urandom_range(0, 80));
                applyStimulus(gap);
                left--;
            end
        end
    endtask

    initial begin
        modelReset();
        mErrExp = 0;
        mLastRise = 0;

        repeat (20) begin
            tick(1);
            tone_in = ~tone_in;
        end
        tone_in = 1'b0;
        tick(2);
        checkState("reset");
        rst_n = 1'b1;
        tick(3);

        repeat (6) applyStimulus(PA);
        applyStimulus(PA + TOLV);
        applyStimulus(PA - TOLV);
        repeat (6) applyStimulus(PA - TOLV + int'($urandom_range(0, 2 * TOLV)));
        applyStimulus(PA + TOLV + 1);
        applyStimulus(PB - TOLV - 1);
        repeat (5) applyStimulus(PA);

        repeat (6) applyStimulus(PB);
        repeat (5) applyStimulus(PA);

        repeat (8) applyStimulus(110 + int'($urandom_range(0, 80)));

        repeat (5) applyStimulus(PA);
        applyStimulus(TMO);
        applyStimulus(TMO + 1);
        repeat (5) applyStimulus(PA);

        holdLow(TMO - 10);
        holdLow(20);
        applyStimulus(PA);
        repeat (5) applyStimulus(PB);

        tick(1);
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkState("asyncrst");
        tick(3);
        rst_n = 1'b1;
        tick(2);

        randomMix(80);

        holdLow(TMO + 20);
        repeat (12) applyStimulus(PA);
        repeat (24) applyStimulus(PB);
        repeat (12) applyStimulus(PA);
        repeat (24) applyStimulus(PB);
        repeat (20) applyStimulus(PA);
        repeat (24) applyStimulus(PB);
        holdLow(TMO + 20);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
